// File: rtl/delay_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_pkg                                                 |
// | Purpose  : Shared state encoding and default constants for the       |
// |            delay_checker latency calibrator.                         |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package delay_pkg;

  // Calibrator states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_CAL    = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam int c_def_max_lat    = 4;
  localparam int c_def_cal_cycles = 8;
  // Latency field is 3 bits so candidates up to 7 fit
  localparam int c_lat_w          = 3;
  localparam logic [7:0] c_cnt_sat = 8'hFF;

  // Larger of two sizes, used to dimension the shared phase counter
  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hist_shift.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hist_shift                                                |
// | Purpose  : Stimulus history shift register. Tap k (1..MAX_LAT) holds |
// |            the input value seen k clock edges earlier; tap k lives   |
// |            at taps_o[(k-1)*W +: W].                                  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module hist_shift #(
  parameter int W       = 3,
  parameter int MAX_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         d_i,
  output logic [MAX_LAT*W-1:0] taps_o
);

  logic [MAX_LAT*W-1:0] hist_q;

  generate
    if (MAX_LAT == 1) begin : g_single
      // Single-stage history: just register the input
      always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= '0;
        else     hist_q <= d_i;
      end
    end else begin : g_multi
      // Shift newest sample into tap 1, older samples move toward tap MAX_LAT
      always_ff @(posedge clk or posedge rst) begin
        if (rst) hist_q <= '0;
        else     hist_q <= {hist_q[(MAX_LAT-1)*W-1:0], d_i};
      end
    end
  endgenerate

  assign taps_o = hist_q;

endmodule
`default_nettype wire

// File: rtl/delay_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : delay_checker                                             |
// | Purpose  : Measures the latency of an external pipeline by matching  |
// |            its output against a history of the stimulus, then keeps  |
// |            checking the locked latency and counts mismatches.        |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module delay_checker
  import delay_pkg::*;
#(
  parameter int W          = 3,
  parameter int MAX_LAT    = c_def_max_lat,
  parameter int CAL_CYCLES = c_def_cal_cycles
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [W-1:0]       in,
  input  logic [W-1:0]       dut_out,
  output logic [c_lat_w-1:0] lat,
  output logic               locked,
  output logic               fail,
  output logic               err,
  output logic [7:0]         mismatch_cnt
);

  // One counter serves both the FILL and CAL phases
  localparam int CW = $clog2(max_i(MAX_LAT, CAL_CYCLES)) + 1;
  localparam logic [CW-1:0] c_fill_last = CW'(MAX_LAT - 1);
  localparam logic [CW-1:0] c_cal_last  = CW'(CAL_CYCLES - 1);

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [MAX_LAT-1:0]   cand_q;      // bit k-1 <-> latency candidate k
  logic [c_lat_w-1:0]   lat_q;
  logic                 locked_q;
  logic                 fail_q;
  logic                 err_q;
  logic [7:0]           mcnt_q;

  logic [MAX_LAT*W-1:0] w_taps;
  logic [MAX_LAT-1:0]   w_match;
  logic [MAX_LAT-1:0]   w_cand_d;
  logic [c_lat_w-1:0]   w_first_lat;
  logic [W-1:0]         w_sel_tap;
  logic                 w_lock_miss;

  hist_shift #(
    .W       (W),
    .MAX_LAT (MAX_LAT)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .d_i    (in),
    .taps_o (w_taps)
  );

  // Per-candidate comparison against the pre-edge history taps
  generate
    for (genvar k = 0; k < MAX_LAT; k++) begin : g_cmp
      assign w_match[k] = (dut_out == w_taps[k*W +: W]);
    end
  endgenerate

  assign w_cand_d = cand_q & w_match;

  // Smallest surviving candidate wins, which resolves constant-stimulus ambiguity
  always_comb begin
    w_first_lat = '0;
    for (int k = MAX_LAT; k >= 1; k--) begin
      if (w_cand_d[k-1]) w_first_lat = c_lat_w'(k);
    end
  end

  // Select the history tap for the locked latency
  always_comb begin
    w_sel_tap = '0;
    for (int k = 1; k <= MAX_LAT; k++) begin
      if (lat_q == c_lat_w'(k)) w_sel_tap = w_taps[(k-1)*W +: W];
    end
  end

  assign w_lock_miss = (dut_out != w_sel_tap);

  // Calibration FSM with registered status outputs; start overrides everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      lat_q    <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
    end else if (start) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      cand_q   <= '0;
      lat_q    <= '0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      err_q    <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
        end
        ST_FILL: begin
          if (cnt_q == c_fill_last) begin
            state_q <= ST_CAL;
            cnt_q   <= '0;
            cand_q  <= '1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_CAL: begin
          cand_q <= w_cand_d;
          if (cnt_q == c_cal_last) begin
            cnt_q <= '0;
            if (|w_cand_d) begin
              state_q  <= ST_LOCKED;
              lat_q    <= w_first_lat;
              locked_q <= 1'b1;
            end else begin
              state_q <= ST_FAIL;
              lat_q   <= '0;
              fail_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_lock_miss) begin
            err_q <= 1'b1;
            if (mcnt_q != c_cnt_sat) mcnt_q <= mcnt_q + 8'd1;
          end
        end
        ST_FAIL: begin
          fail_q <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign lat          = lat_q;
  assign locked       = locked_q;
  assign fail         = fail_q;
  assign err          = err_q;
  assign mismatch_cnt = mcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_delay_checker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_delay_checker                                          |
// | Purpose  : Directed self-checking bench for delay_checker with a     |
// |            selectable behavioural pipeline as the device under test. |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_delay_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] in_v;
  logic [2:0] dut_out;
  logic [2:0] lat;
  logic       locked;
  logic       fail;
  logic       err;
  logic [7:0] mismatch_cnt;

  // Behavioural pipeline under test
  logic [2:0] p1 = '0, p2 = '0, p3 = '0;
  int         mode = 0;        // 0: 3-stage, 1: 1-stage, 2: tied 3'b101
  logic [2:0] flip = '0;
  logic       ramp_en = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Three nonblocking stages fed by the stimulus
  always @(posedge clk) begin
    p1 <= in_v;
    p2 <= p1;
    p3 <= p2;
  end

  // Output selection of the pipeline under test, with optional bit corruption
  always_comb begin
    dut_out = p3;
    case (mode)
      1:       dut_out = p1;
      2:       dut_out = 3'b101;
      default: dut_out = p3;
    endcase
    dut_out = dut_out ^ flip;
  end

  delay_checker #(
    .W          (3),
    .MAX_LAT    (4),
    .CAL_CYCLES (8)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in           (in_v),
    .dut_out      (dut_out),
    .lat          (lat),
    .locked       (locked),
    .fail         (fail),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n edges; inputs change 1 time unit after each edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ramp_en) in_v = in_v + 3'd1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lat"},    lat,          0);
    check({tag, "_locked"}, locked,       0);
    check({tag, "_fail"},   fail,         0);
    check({tag, "_err"},    err,          0);
    check({tag, "_mcnt"},   mismatch_cnt, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    in_v  = 3'd0;

    // Reset state
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(2);
    check("idle_locked", locked, 0);

    // 3-stage pipeline, ramp: lock exactly 12 edges after the start edge
    mode = 0;
    pulse_start();
    tick(11);
    check("p3_prelock", locked, 0);
    tick(1);
    check("p3_locked", locked, 1);
    check("p3_lat",    lat,    3);
    check("p3_err",    err,    0);
    check("p3_fail",   fail,   0);
    tick(5);
    check("p3_mcnt_clean", mismatch_cnt, 0);

    // 1-stage pipeline
    mode = 1;
    pulse_start();
    check("p1_restart_lat",    lat,    0);
    check("p1_restart_locked", locked, 0);
    tick(12);
    check("p1_locked", locked,       1);
    check("p1_lat",    lat,          1);
    check("p1_mcnt",   mismatch_cnt, 0);

    // Output tied to 3'b101 -> no candidate survives
    mode = 2;
    pulse_start();
    tick(12);
    check("tied_fail",   fail,   1);
    check("tied_lat",    lat,    0);
    check("tied_locked", locked, 0);
    tick(3);
    check("tied_fail_hold", fail, 1);

    // Constant stimulus: every candidate matches, smallest wins
    mode    = 0;
    ramp_en = 1'b0;
    in_v    = 3'd2;
    pulse_start();
    tick(12);
    check("const_locked", locked, 1);
    check("const_lat",    lat,    1);
    ramp_en = 1'b1;

    // Lock at 3 then corrupt one bit until the counter saturates
    pulse_start();
    tick(12);
    check("sat_lock_lat", lat, 3);
    flip = 3'b001;
    tick(1);
    check("sat_first_mcnt", mismatch_cnt, 1);
    check("sat_first_err",  err,          1);
    tick(299);
    check("sat_mcnt_255", mismatch_cnt, 255);
    tick(5);
    check("sat_mcnt_hold", mismatch_cnt, 255);
    check("sat_err",       err,          1);
    check("sat_locked",    locked,       1);

    // Restart while locked with err set
    flip = 3'b000;
    pulse_start();
    check("restart_err",  err,          0);
    check("restart_mcnt", mismatch_cnt, 0);
    tick(12);
    check("restart_locked", locked, 1);
    check("restart_lat",    lat,    3);
    check("restart_err2",   err,    0);

    // Asynchronous reset while locked clears outputs before the next edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_locked_lat",    lat,    0);
    check("arst_locked_locked", locked, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Asynchronous reset mid-CAL, then stays idle until start
    pulse_start();
    tick(6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("arst_cal");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(20);
    check("post_rst_idle_locked", locked, 0);
    check("post_rst_idle_fail",   fail,   0);
    pulse_start();
    tick(11);
    check("post_rst_prelock", locked, 0);
    tick(1);
    check("post_rst_locked", locked, 1);
    check("post_rst_lat",    lat,    3);

    // Start re-pulsed mid-CAL restarts the full FILL+CAL sequence
    pulse_start();
    tick(8);
    pulse_start();
    tick(11);
    check("recal_prelock", locked, 0);
    tick(1);
    check("recal_locked", locked, 1);
    check("recal_lat",    lat,    3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
